// File: rtl/hw_button_pio.sv
// Debounced push-button/switch input port with sticky edge capture
// and a maskable level interrupt on an Avalon-MM slave.
module hw_button_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int INIT_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT_VEC =
    (INIT_LEVEL != 0) ? '1 : '0;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_stb;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  logic [WIDTH-1:0] w_syn;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_syn    = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_syn ^ r_stb;
  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  // Multi-flop synchroniser for the raw asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        r_sync[k] <= INIT_VEC;
    end else begin
      r_sync[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_sync[k] <= r_sync[k-1];
    end
  end

  // A channel is accepted when it has differed for the full window
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < WIDTH; i++)
      w_hit[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
  end

  // Per-channel stability counters; any agreement restarts the window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_hit[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  // Debounced level flips only on an accepted channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stb <= INIT_VEC;
    else
      r_stb <= r_stb ^ w_hit;
  end

  // Qualifying-edge select on the debounced level
  always_comb begin
    w_set = '0;
    if (EDGE_TYPE == 0)
      w_set = w_hit & w_syn;
    else if (EDGE_TYPE == 1)
      w_set = w_hit & ~w_syn;
    else
      w_set = w_hit;
  end

  assign w_clr = (w_wr && address == 2'd3) ?
                 writedata[WIDTH-1:0] : '0;

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_mask <= '0;
    else if (w_wr && address == 2'd2)
      r_mask <= writedata[WIDTH-1:0];
  end

  // Sticky edge capture; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_edge <= '0;
    else
      r_edge <= (r_edge & ~w_clr) | w_set;
  end

  // Read mux, upper bits zero
  always_comb begin
    w_rdata = '0;
    unique case (address)
      2'd0: w_rdata[WIDTH-1:0] = r_stb;
      2'd1: w_rdata[WIDTH-1:0] = w_syn;
      2'd2: w_rdata[WIDTH-1:0] = r_mask;
      2'd3: w_rdata[WIDTH-1:0] = r_edge;
      default: w_rdata = '0;
    endcase
  end

  // Read data registered every cycle, no side effects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= w_rdata;
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_hw_button_pio.sv
// Directed bench for hw_button_pio: debounce latency, glitch
// rejection, edge capture, RW1C, mask/irq and async reset.
module tb_hw_button_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp;
  int n_bad;

  hw_button_pio #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1),
    .INIT_LEVEL(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag,
                    input logic [31:0] exp);
    address = a;
    tick();
    chk(tag, readdata, exp);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    ticks(3);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

    // 1: idle state after reset
    rd(2'd0, "t1_data", 32'hF);
    rd(2'd3, "t1_edge", 32'h0);
    chk("t1_irq", {31'h0, irq}, 32'h0);
    rd(2'd2, "t1_mask", 32'h0);

    // 2: clean fall on ch0, stb changes at edge 6
    address = 2'd0;
    tick();
    in_port = 4'hE;
    ticks(6);
    chk("t2_data_e6", readdata, 32'hF);
    tick();
    chk("t2_data_e7", readdata, 32'hE);
    rd(2'd3, "t2_edge", 32'h1);
    chk("t2_irq_masked", {31'h0, irq}, 32'h0);

    // 3: 3-cycle glitch on ch1 is rejected
    address = 2'd1;
    tick();
    in_port = 4'hC;
    ticks(3);
    chk("t3_raw_pulse", readdata, 32'hC);
    in_port = 4'hE;
    ticks(3);
    chk("t3_raw_back", readdata, 32'hE);
    ticks(6);
    rd(2'd0, "t3_data", 32'hE);
    rd(2'd3, "t3_edge", 32'h1);

    // 4: mask and RW1C clear drive irq
    wr(2'd2, 32'h1);
    chk("t4_irq_set", {31'h0, irq}, 32'h1);
    rd(2'd2, "t4_mask", 32'h1);
    wr(2'd3, 32'h1);
    chk("t4_irq_clr", {31'h0, irq}, 32'h0);
    rd(2'd3, "t4_edge", 32'h0);

    // 5: clear coinciding with a new ch2 fall loses
    in_port = 4'hA;
    ticks(5);
    wr(2'd3, 32'h4);
    rd(2'd3, "t5_edge_kept", 32'h4);
    chk("t5_irq_masked", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h4);
    chk("t5_irq_on", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h4);
    chk("t5_irq_off", {31'h0, irq}, 32'h0);
    rd(2'd3, "t5_edge_clr", 32'h0);
    in_port = 4'hF;
    ticks(8);
    rd(2'd0, "t5_data_rise", 32'hF);
    rd(2'd3, "t5_no_rise_cap", 32'h0);

    // 6: async reset mid-count on ch3
    address = 2'd0;
    in_port = 4'h7;
    ticks(4);
    chk("t6_pre_rst", readdata, 32'hF);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rdata", readdata, 32'h0);
    chk("t6_rst_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hF;
    ticks(2);
    reset_n = 1'b1;
    ticks(8);
    chk("t6_irq_idle", {31'h0, irq}, 32'h0);
    rd(2'd0, "t6_data", 32'hF);
    rd(2'd1, "t6_raw", 32'hF);
    rd(2'd2, "t6_mask", 32'h0);
    rd(2'd3, "t6_edge", 32'h0);

    // fresh count after reset: irq rises exactly at edge 6
    wr(2'd2, 32'h8);
    in_port = 4'h7;
    ticks(5);
    chk("t6_irq_e5", {31'h0, irq}, 32'h0);
    tick();
    chk("t6_irq_e6", {31'h0, irq}, 32'h1);
    rd(2'd3, "t6_edge_ch3", 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
